// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU port-I/O responder.
//   DATA_W    : width of each I/O port and of event data
//   DEPTH     : event FIFO entries (power of two, >= 2)
//   PTR_W     : log2(DEPTH)
//   DEPTH_CNT : DEPTH at occupancy-counter width
//   evt_t     : event record {port, data}
//   state_t   : responder FSM states
package cpu_io_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned PTR_W  = 3;

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  typedef struct packed {
    logic              port;
    logic [DATA_W-1:0] data;
  } evt_t;

  typedef enum logic {
    ST_ARM,
    ST_RUN
  } state_t;

endpackage

// File: rtl/io_evt_fifo.sv
// Dual-push (ordered), single-pop event FIFO.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   push0_en/push0_evt  : first-priority push (lower slot when both push)
//   push1_en/push1_evt  : second push
//   pop_req             : consumer ready; pops head when non-empty
//   head/valid          : head entry and non-empty flag
//   count               : occupancy 0..DEPTH
//   drop                : combinational, an offered event is not stored this cycle
module io_evt_fifo
  import cpu_io_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           push0_en,
  input  evt_t           push0_evt,
  input  logic           push1_en,
  input  evt_t           push1_evt,
  input  logic           pop_req,
  output evt_t           head,
  output logic           valid,
  output logic [PTR_W:0] count,
  output logic           drop
);

  evt_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   free;
  logic             acc_first;
  logic             acc_second;
  logic             pop;
  evt_t             first_evt;

  // Free space is taken before this cycle's pop, so a simultaneous pop
  // never makes room for a push in the same cycle.
  always_comb begin
    free       = DEPTH_CNT - count;
    first_evt  = push0_en ? push0_evt : push1_evt;
    acc_first  = (push0_en | push1_en) && (free != '0);
    acc_second = push0_en && push1_en && (free >= (PTR_W + 1)'(2));
    drop       = ((push0_en | push1_en) && (free == '0)) ||
                 (push0_en && push1_en && (free == (PTR_W + 1)'(1)));
    pop        = pop_req && (count != '0);
  end

  always_ff @(posedge clock) begin
    if (acc_first)  mem[wr_ptr]             <= first_evt;
    if (acc_second) mem[wr_ptr + PTR_W'(1)] <= push1_evt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(acc_first) + PTR_W'(acc_second);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + (PTR_W + 1)'(acc_first) + (PTR_W + 1)'(acc_second)
                - (PTR_W + 1)'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (count != '0);

endmodule

// File: rtl/cpu_io_port_responder.sv
// Device-side end of the CPU port I/O.
//   clock, reset              : CPU clock, synchronous active-high reset
//   out_port0/1               : CPU output ports, watched for value changes
//   in_port0/1                : CPU input ports, registered, host-written
//   host_wr_en/sel/data       : host write into in_port[sel]
//   evt_valid/ready/port/data : event stream from FIFO head
//   evt_count                 : FIFO occupancy
//   overflow/clr_overflow     : sticky drop flag and its clear
module cpu_io_port_responder
  import cpu_io_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] out_port0,
  input  logic [DATA_W-1:0] out_port1,
  output logic [DATA_W-1:0] in_port0,
  output logic [DATA_W-1:0] in_port1,
  input  logic              host_wr_en,
  input  logic              host_wr_sel,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic              evt_port,
  output logic [DATA_W-1:0] evt_data,
  output logic [PTR_W:0]    evt_count,
  output logic              overflow,
  input  logic              clr_overflow
);

  state_t            state;
  logic [DATA_W-1:0] prev0;
  logic [DATA_W-1:0] prev1;
  logic              chg0;
  logic              chg1;
  logic              fifo_drop;
  evt_t              evt0;
  evt_t              evt1;
  evt_t              head;

  // ARM only snapshots the ports, so a value present across reset is not reported.
  always_comb begin
    chg0      = (state == ST_RUN) && (out_port0 != prev0);
    chg1      = (state == ST_RUN) && (out_port1 != prev1);
    evt0.port = 1'b0;
    evt0.data = out_port0;
    evt1.port = 1'b1;
    evt1.data = out_port1;
  end

  io_evt_fifo u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push0_en  (chg0),
    .push0_evt (evt0),
    .push1_en  (chg1),
    .push1_evt (evt1),
    .pop_req   (evt_ready),
    .head      (head),
    .valid     (evt_valid),
    .count     (evt_count),
    .drop      (fifo_drop)
  );

  assign evt_port = head.port;
  assign evt_data = head.data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_ARM;
      prev0    <= '0;
      prev1    <= '0;
      in_port0 <= '0;
      in_port1 <= '0;
      overflow <= 1'b0;
    end else begin
      state <= ST_RUN;
      prev0 <= out_port0;
      prev1 <= out_port1;
      if (host_wr_en) begin
        if (host_wr_sel) in_port1 <= host_wr_data;
        else             in_port0 <= host_wr_data;
      end
      // A drop wins over a clear in the same cycle.
      if (fifo_drop)         overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule
